// File: rtl/dice_roll_ctrl.sv
// rtl/dice_roll_ctrl.sv - electronic dice roll controller with BCD display value
//
// Purpose: selects a die (d4..d100) from the button bank, spins the value
// while the button is held, settles over eight ticks, then holds the result
// and blanks the display after 60 s of inactivity.
//
// Ports:
//   clk      system clock (32768 Hz)
//   rst      asynchronous active-high reset
//   tick     one-cycle 32 Hz pulse from the prescaler
//   btn      debounced button levels, bit0..6 = d4, d6, d8, d10, d12, d20, d100
//   digit1   BCD units digit of the die value
//   digit10  BCD tens digit of the die value (00 shows the d100 value 100)
//   rolling  high while spinning or settling
//   blank    high while asleep (display off)
//   done     one-cycle pulse when a roll result becomes final

module dice_roll_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [6:0] btn,
    output logic [3:0] digit1,
    output logic [3:0] digit10,
    output logic       rolling,
    output logic       blank,
    output logic       done
);

    typedef enum logic [1:0] {HOLD, SPIN, SETTLE, SLEEP} state_t;

    localparam logic [10:0] IDLE_LAST = 11'd1919;

    state_t      state;
    logic [7:0]  n_enc;       // BCD encoding of the latched number of sides
    logic [6:0]  btn_prev;
    logic        armed;       // set once btn has been seen at zero after reset
    logic [2:0]  settle_cnt;
    logic [10:0] idle_cnt;

    logic        press;
    logic [7:0]  press_enc;
    logic [7:0]  step_val;

    // A button still held through reset must be released before it counts.
    always_comb press = armed && (btn != 7'd0) && (btn_prev == 7'd0);

    // Lowest set button wins.
    always_comb begin
        press_enc = 8'h06;
        if (btn[0])      press_enc = 8'h04;
        else if (btn[1]) press_enc = 8'h06;
        else if (btn[2]) press_enc = 8'h08;
        else if (btn[3]) press_enc = 8'h10;
        else if (btn[4]) press_enc = 8'h12;
        else if (btn[5]) press_enc = 8'h20;
        else if (btn[6]) press_enc = 8'h00;
    end

    // Count down in BCD, wrapping 01 back to N; 00 (=100) wraps to 99.
    always_comb begin
        step_val = {digit10, digit1};
        if ({digit10, digit1} == 8'h01) begin
            step_val = n_enc;
        end else if (digit1 == 4'd0) begin
            if (digit10 == 4'd0) step_val = 8'h99;
            else                 step_val = {digit10 - 4'd1, 4'd9};
        end else begin
            step_val = {digit10, digit1 - 4'd1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HOLD;
            n_enc      <= 8'h06;
            digit10    <= 4'd0;
            digit1     <= 4'd1;
            rolling    <= 1'b0;
            blank      <= 1'b0;
            done       <= 1'b0;
            btn_prev   <= 7'd0;
            armed      <= 1'b0;
            settle_cnt <= 3'd0;
            idle_cnt   <= 11'd0;
        end else begin
            btn_prev <= btn;
            done     <= 1'b0;
            if (btn == 7'd0) armed <= 1'b1;

            if (press && state != SPIN) begin
                // Press outranks a coincident tick in every accepting state.
                n_enc             <= press_enc;
                {digit10, digit1} <= press_enc;
                state             <= SPIN;
                rolling           <= 1'b1;
                blank             <= 1'b0;
                settle_cnt        <= 3'd0;
            end else begin
                case (state)
                    HOLD: begin
                        if (tick) begin
                            if (idle_cnt == IDLE_LAST) begin
                                state <= SLEEP;
                                blank <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + 11'd1;
                            end
                        end
                    end
                    SPIN: begin
                        if (btn == 7'd0) begin
                            state      <= SETTLE;
                            settle_cnt <= 3'd0;
                        end else begin
                            {digit10, digit1} <= step_val;
                        end
                    end
                    SETTLE: begin
                        if (tick) begin
                            {digit10, digit1} <= step_val;
                            if (settle_cnt == 3'd7) begin
                                state    <= HOLD;
                                rolling  <= 1'b0;
                                done     <= 1'b1;
                                idle_cnt <= 11'd0;
                            end else begin
                                settle_cnt <= settle_cnt + 3'd1;
                            end
                        end
                    end
                    SLEEP: begin
                        // Value retained; only a press leaves this state.
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end

endmodule
